// File: rtl/sram_1r1w_bw_init.sv
// One-read/one-write SRAM model with per-group write mask, write-first collision
// forwarding, holding read port and a zero-fill sequence that runs after reset.
module sram_1r1w_bw_init #(
   parameter int Bits           = 128,
   parameter int Word_Depth     = 64,
   parameter int Add_Width      = 6,
   parameter int Wen_Width      = 128,
   parameter int Clear_On_Reset = 1
) (
   input  logic                 CLK,
   input  logic                 RSTB,
   input  logic                 CEBR,
   input  logic [Add_Width-1:0] AR,
   output logic [Bits-1:0]      Q,
   input  logic                 CEBW,
   input  logic [Add_Width-1:0] AW,
   input  logic [Bits-1:0]      D,
   input  logic [Wen_Width-1:0] BWEB,
   output logic                 READY
);

   localparam int G = Bits / Wen_Width;
   localparam logic [Add_Width:0]   DEPTH = (Add_Width+1)'(Word_Depth);
   localparam logic [Add_Width-1:0] LAST  = Add_Width'(Word_Depth - 1);

   typedef enum logic [1:0] {RST, INIT, RUN} state_t;

   state_t               state;
   state_t               state_nxt;
   logic [Add_Width-1:0] cnt;
   logic [Bits-1:0]      ram [Word_Depth];

   logic [Bits-1:0] bwen;
   logic [Bits-1:0] old_word;
   logic [Bits-1:0] merged;
   logic            aw_ok;
   logic            ar_ok;
   logic            hit;
   logic            clr_en;
   logic            wr_en;
   logic            rd_en;

   assign aw_ok    = ({1'b0, AW} < DEPTH);
   assign ar_ok    = ({1'b0, AR} < DEPTH);
   assign old_word = aw_ok ? ram[AW] : '0;
   assign merged   = (D & bwen) | (old_word & ~bwen);
   assign hit      = !CEBW && aw_ok && (AR == AW);

   // Each active-low mask bit expands to cover its group of G data bits.
   always_comb begin
      bwen = '0;
      for (int i = 0; i < Wen_Width; i++) begin
         bwen[i*G +: G] = {G{~BWEB[i]}};
      end
   end

   always_comb begin
      state_nxt = state;
      clr_en    = 1'b0;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      case (state)
         RST: begin
            if (Clear_On_Reset != 0) begin
               clr_en    = 1'b1;
               state_nxt = (cnt == LAST) ? RUN : INIT;
            end else begin
               state_nxt = RUN;
            end
         end
         INIT: begin
            clr_en = 1'b1;
            if (cnt == LAST) state_nxt = RUN;
         end
         RUN: begin
            wr_en = !CEBW && aw_ok;
            rd_en = !CEBR;
         end
         default: state_nxt = RST;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTB) begin
         state <= RST;
         cnt   <= '0;
         Q     <= '0;
         READY <= 1'b0;
      end else begin
         state <= state_nxt;
         READY <= (state_nxt == RUN);
         if (clr_en) cnt <= cnt + Add_Width'(1);
         if (rd_en) Q <= ar_ok ? (hit ? merged : ram[AR]) : '0;
      end
   end

   // The array itself is never reset; a reset edge leaves contents untouched.
   always_ff @(posedge CLK) begin
      if (RSTB) begin
         if (clr_en) ram[cnt] <= '0;
         else if (wr_en) ram[AW] <= merged;
      end
   end

endmodule
